// File: rtl/cu_sequencer.sv
// Two-cycle FETCH/EXEC sequencer driving the 16x8 register bank and the ALU op select.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (undefined opcodes trap to ERR and raise err).
module cu_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 8
) (
`ifdef CU_ILLEGAL_TRAP_EN
    output logic            err,
`endif
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr_data,
    output logic [2:0]      InMuxAdd,
    output logic [3:0]      OutMuxAdd,
    output logic [3:0]      RegAdd,
    output logic            WE,
    output logic [7:0]      CUconst,
    output logic [3:0]      ALUsel
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_ALU  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_LOOP = 4'h7;
    localparam logic [3:0] OP_DJNZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] loopCnt;
    logic             weDec;

    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] imm;

    assign op  = instr_data[15:12];
    assign rd  = instr_data[11:8];
    assign imm = instr_data[7:0];

    assign instr_addr = pc;
    assign busy       = (state == FETCH) || (state == EXEC);
    assign done       = (state == DONE);
`ifdef CU_ILLEGAL_TRAP_EN
    assign err        = (state == ERR);
`endif

    // Bank controls decode straight from the ROM word so the write lands on the edge ending EXEC.
    always_comb begin
        InMuxAdd  = '0;
        OutMuxAdd = '0;
        RegAdd    = '0;
        weDec     = 1'b0;
        CUconst   = '0;
        ALUsel    = '0;
        if (state == EXEC) begin
            case (op)
                OP_LDA: begin
                    InMuxAdd = 3'd0;
                    RegAdd   = rd;
                    weDec    = 1'b1;
                end
                OP_LDB: begin
                    InMuxAdd = 3'd1;
                    RegAdd   = rd;
                    weDec    = 1'b1;
                end
                OP_LDI: begin
                    InMuxAdd = 3'd2;
                    CUconst  = imm;
                    RegAdd   = rd;
                    weDec    = 1'b1;
                end
                OP_ALU: begin
                    InMuxAdd = 3'd3;
                    ALUsel   = imm[3:0];
                    RegAdd   = rd;
                    weDec    = 1'b1;
                end
                OP_MOV: begin
                    InMuxAdd  = 3'd4;
                    OutMuxAdd = imm[3:0];
                    RegAdd    = rd;
                    weDec     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset must block a write even while EXEC is still the current state.
    assign WE = weDec & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            loopCnt <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= FETCH;
                FETCH: state <= EXEC;
                EXEC: begin
                    state <= FETCH;
                    pc    <= pc + PC_W'(1);
                    case (op)
                        OP_NOP, OP_LDA, OP_LDB, OP_LDI, OP_ALU, OP_MOV: ;
                        OP_LOOP: loopCnt <= CNT_W'(imm);
                        OP_DJNZ: begin
                            if (loopCnt > CNT_W'(1)) begin
                                loopCnt <= loopCnt - CNT_W'(1);
                                pc      <= PC_W'(imm);
                            end else begin
                                loopCnt <= '0;
                            end
                        end
                        OP_JMP: pc <= PC_W'(imm);
                        OP_HALT: begin
                            state <= DONE;
                            pc    <= '0;
                        end
                        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                            state <= ERR;
`endif
                        end
                    endcase
                end
                DONE:    state <= IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: per-cycle vector tables plus hand-written corner runs.
module tb_cu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, WE;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [2:0]  InMuxAdd;
    logic [3:0]  OutMuxAdd, RegAdd, ALUsel;
    logic [7:0]  CUconst;
`ifdef CU_ILLEGAL_TRAP_EN
    logic        err;
`endif

    cu_sequencer #(.PC_W(8), .CNT_W(8)) dut (
`ifdef CU_ILLEGAL_TRAP_EN
        .err(err),
`endif
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .InMuxAdd(InMuxAdd), .OutMuxAdd(OutMuxAdd), .RegAdd(RegAdd), .WE(WE),
        .CUconst(CUconst), .ALUsel(ALUsel)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: word appears one cycle after its address.
    logic [15:0] mem [0:255];
    always @(posedge clk) instr_data <= mem[instr_addr];

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       we;
        logic [2:0] inMux;
        logic [3:0] outMux;
        logic [3:0] regAdd;
        logic [7:0] cuConst;
        logic [3:0] aluSel;
        logic [7:0] addr;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    obs_t trace [0:63];
    int   weCount, doneCount, doneCyc, busyCount;
    int   weRegs[$];
    int   addrSeq[$];

    function automatic obs_t mk(input logic b, input logic d, input logic w, input int im,
                                input int om, input int ra, input int cc, input int al,
                                input int ad);
        obs_t o;
        o.busy = b; o.done = d; o.we = w;
        o.inMux = 3'(im); o.outMux = 4'(om); o.regAdd = 4'(ra);
        o.cuConst = 8'(cc); o.aluSel = 4'(al); o.addr = 8'(ad);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy; o.done = done; o.we = WE;
        o.inMux = InMuxAdd; o.outMux = OutMuxAdd; o.regAdd = RegAdd;
        o.cuConst = CUconst; o.aluSel = ALUsel; o.addr = instr_addr;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Runs nCyc cycles from the current negedge (cycle 0). mode 0: start pulse at cycle 0,
    // 1: extra pulses during busy (3) and DONE (9), 2: start held high throughout.
    task automatic runProg(input int nCyc, input int mode, input int patchCyc,
                           input int patchAddr, input logic [15:0] patchData);
        obs_t o;
        weCount = 0; doneCount = 0; doneCyc = -1; busyCount = 0;
        weRegs.delete();
        addrSeq.delete();
        for (int c = 0; c < nCyc; c++) begin
            start = (mode == 2) || (c == 0) || (mode == 1 && (c == 3 || c == 9));
            if (c == patchCyc) mem[patchAddr] = patchData;
            #1;
            o = sample();
            trace[c] = o;
            if (o.we) begin
                weCount++;
                weRegs.push_back(int'(o.regAdd));
            end
            if (o.done) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = c;
            end
            if (o.busy) busyCount++;
            if (o.busy && (c % 2 == 1)) addrSeq.push_back(int'(o.addr));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    function automatic int seqAt(input int i);
        return (addrSeq.size() > i) ? addrSeq[i] : -1;
    endfunction

    vec_t tabA [11];
    vec_t tabB [4];

    initial begin
        int bad;

        // Program A: LDI R1,5; LDI R2,3; ALU R0,2; HALT -- full per-cycle trace.
        tabA[0]  = '{0,  mk(0,0,0,0,0,0,0,0,0)};
        tabA[1]  = '{1,  mk(1,0,0,0,0,0,0,0,0)};
        tabA[2]  = '{2,  mk(1,0,1,2,0,1,5,0,0)};
        tabA[3]  = '{3,  mk(1,0,0,0,0,0,0,0,1)};
        tabA[4]  = '{4,  mk(1,0,1,2,0,2,3,0,1)};
        tabA[5]  = '{5,  mk(1,0,0,0,0,0,0,0,2)};
        tabA[6]  = '{6,  mk(1,0,1,3,0,0,0,2,2)};
        tabA[7]  = '{7,  mk(1,0,0,0,0,0,0,0,3)};
        tabA[8]  = '{8,  mk(1,0,0,0,0,0,0,0,3)};
        tabA[9]  = '{9,  mk(0,1,0,0,0,0,0,0,0)};
        tabA[10] = '{10, mk(0,0,0,0,0,0,0,0,0)};
        // Program B: LDA R1; LDB R2; MOV R3,R12; HALT -- EXEC cycles and done.
        tabB[0]  = '{2,  mk(1,0,1,0,0,1,0,0,0)};
        tabB[1]  = '{4,  mk(1,0,1,1,0,2,0,0,1)};
        tabB[2]  = '{6,  mk(1,0,1,4,12,3,0,0,2)};
        tabB[3]  = '{9,  mk(0,1,0,0,0,0,0,0,0)};

        clearMem();
        doReset();
        #1;
        check("reset_state", 64'(sample()), 64'(mk(0,0,0,0,0,0,0,0,0)));
        @(negedge clk);

        clearMem();
        mem[0] = 16'h3105; mem[1] = 16'h3203; mem[2] = 16'h4002; mem[3] = 16'hF000;
        runProg(12, 0, -1, 0, 16'h0);
        foreach (tabA[i]) check($sformatf("progA_cyc%0d", tabA[i].cyc),
                                64'(trace[tabA[i].cyc]), 64'(tabA[i].exp));

        doReset();
        clearMem();
        mem[0] = 16'h1100; mem[1] = 16'h2200; mem[2] = 16'h530C; mem[3] = 16'hF000;
        runProg(12, 0, -1, 0, 16'h0);
        foreach (tabB[i]) check($sformatf("progB_cyc%0d", tabB[i].cyc),
                                64'(trace[tabB[i].cyc]), 64'(tabB[i].exp));

        // Loop: LOOP 3; LDA R3; DJNZ 1; HALT
        doReset();
        clearMem();
        mem[0] = 16'h7003; mem[1] = 16'h1300; mem[2] = 16'h8001; mem[3] = 16'hF000;
        runProg(24, 0, -1, 0, 16'h0);
        check("loop_we_count", weCount, 3);
        bad = 0;
        foreach (weRegs[i]) if (weRegs[i] != 3) bad++;
        check("loop_we_regs", bad, 0);
        check("loop_done_cyc", doneCyc, 17);
        check("loop_cnt_after", dut.loopCnt, 0);

        // DJNZ with a zero counter falls through.
        doReset();
        clearMem();
        mem[0] = 16'h8005; mem[1] = 16'hF000; mem[5] = 16'h9005;
        runProg(12, 0, -1, 0, 16'h0);
        check("djnz0_done_cyc", doneCyc, 5);
        check("djnz0_addr1", seqAt(1), 1);

        // PC wrap: JMP 255, NOP at 255, HALT at 0 (word 0 rewritten after the jump is read).
        doReset();
        clearMem();
        mem[0] = 16'h90FF; mem[255] = 16'h0000;
        runProg(12, 0, 3, 0, 16'hF000);
        check("wrap_addr_len", addrSeq.size(), 3);
        check("wrap_addr0", seqAt(0), 0);
        check("wrap_addr1", seqAt(1), 255);
        check("wrap_addr2", seqAt(2), 0);
        check("wrap_done_cyc", doneCyc, 7);
        check("wrap_no_we", weCount, 0);

        // Reset during EXEC of LDI R4,9 (preceded by LOOP 5 so pc and count are nonzero).
        doReset();
        clearMem();
        mem[0] = 16'h7005; mem[1] = 16'h3409;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pre_we", WE, 1);
        reset = 1'b1;
        #1;
        check("rst_we_blocked", WE, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_addr", instr_addr, 0);
        check("rst_loopcnt", dut.loopCnt, 0);
        @(negedge clk);
        #1;
        check("rst_stays_idle", busy, 0);
        @(negedge clk);

        // start pulses during busy and DONE are ignored.
        doReset();
        clearMem();
        mem[0] = 16'h3105; mem[1] = 16'h3203; mem[2] = 16'h4002; mem[3] = 16'hF000;
        runProg(30, 1, -1, 0, 16'h0);
        check("ign_done_count", doneCount, 1);
        check("ign_busy_cycles", busyCount, 8);

        // start held high relaunches straight from IDLE.
        doReset();
        clearMem();
        mem[0] = 16'hF000;
        runProg(10, 2, -1, 0, 16'h0);
        check("hold_done_count", doneCount, 2);
        check("hold_first_done", doneCyc, 3);

        // Undefined opcode 0xA followed by HALT.
        doReset();
        clearMem();
        mem[0] = 16'hA000; mem[1] = 16'hF000;
        runProg(12, 0, -1, 0, 16'h0);
`ifdef CU_ILLEGAL_TRAP_EN
        check("trap_no_done", doneCount, 0);
        check("trap_err", err, 1);
        check("trap_busy_cycles", busyCount, 2);
        check("trap_no_we", weCount, 0);
`else
        check("undef_done_cyc", doneCyc, 5);
        check("undef_no_we", weCount, 0);
        check("undef_busy_cycles", busyCount, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
